// File: rtl/savomax_pkg.sv
// savomax_pkg: format codes, detector FSM states and microsecond-to-clock conversion
package savomax_pkg;
  localparam logic [2:0] FORMAT_UNKNOWN = 3'b000;
  localparam logic [2:0] FORMAT_NTSC    = 3'b010;
  localparam logic [2:0] FORMAT_PAL     = 3'b100;
  typedef enum logic [1:0] {NO_SIGNAL, ACQUIRE, LOCKED} state_t;
  function automatic int us_to_clks(input int clk_freq, input int us);
    return (clk_freq / 1000) * us / 1000;
  endfunction
endpackage

// File: rtl/vsync_edge_sync.sv
// vsync_edge_sync: 2-flop synchroniser + delay flop, one-cycle pulse on the selected VSYNC edge
//   clk_in, rst_in (async, active-high); vsync_in raw VSYNC; pol_in 0=falling 1=rising; edge_o detect pulse
module vsync_edge_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic vsync_in,
  input  logic pol_in,
  output logic edge_o
);
  logic [1:0] sync_q;
  logic       dly_q;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      sync_q <= {2{~pol_in}};
      dly_q  <= ~pol_in;
    end else begin
      sync_q <= {sync_q[0], vsync_in};
      dly_q  <= sync_q[1];
    end
  assign edge_o = pol_in ? (sync_q[1] & ~dly_q) : (~sync_q[1] & dly_q);
endmodule

// File: rtl/video_std_detect.sv
// video_std_detect: continuous NTSC/PAL detection from VSYNC period with lock hysteresis and loss-of-signal
//   clk_in, rst_in (async, active-high); vsync_in, vsync_pol_in, csync_in inputs
//   csync_out pass-through; format_out 000/010/100; format_valid_out locked; period_out last period;
//   format_change_out one-cycle pulse on format change; signal_lost_out no edge within MAX_CLKS
module video_std_detect
  import savomax_pkg::*;
#(
  parameter int CLK_FREQ      = 250_000,
  parameter int PERIOD_W      = 32,
  parameter int THRESHOLD_US  = 18_000,
  parameter int MIN_PERIOD_US = 10_000,
  parameter int MAX_PERIOD_US = 30_000,
  parameter int LOCK_COUNT    = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                vsync_in,
  input  logic                vsync_pol_in,
  input  logic                csync_in,
  output logic                csync_out,
  output logic [2:0]          format_out,
  output logic                format_valid_out,
  output logic [PERIOD_W-1:0] period_out,
  output logic                format_change_out,
  output logic                signal_lost_out
);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [PERIOD_W-1:0] THR_CLKS = PERIOD_W'(us_to_clks(CLK_FREQ, THRESHOLD_US));
  localparam logic [PERIOD_W-1:0] MIN_CLKS = PERIOD_W'(us_to_clks(CLK_FREQ, MIN_PERIOD_US));
  localparam logic [PERIOD_W-1:0] MAX_CLKS = PERIOD_W'(us_to_clks(CLK_FREQ, MAX_PERIOD_US));
  localparam logic [PERIOD_W-1:0] SAT_CLKS = MAX_CLKS + PERIOD_W'(1);
  localparam logic [CW-1:0]       LOCK_N   = CW'(LOCK_COUNT);
  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [2:0]          fmt_q, fmt_d, cand_q, cand_d, miss_cls_q, miss_cls_d, cls;
  logic [CW-1:0]       match_q, match_d, miss_q, miss_d, match_inc, miss_inc;
  logic                valid_q, valid_d, chg_q, chg_d, lost_q, lost_d;
  logic                vs_edge, oor, tout;
  vsync_edge_sync u_sync (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .vsync_in(vsync_in),
    .pol_in  (vsync_pol_in),
    .edge_o  (vs_edge)
  );
  assign cls = (cnt_q < MIN_CLKS || cnt_q > MAX_CLKS) ? FORMAT_UNKNOWN :
               (cnt_q > THR_CLKS) ? FORMAT_PAL : FORMAT_NTSC;
  assign oor = cls == FORMAT_UNKNOWN;
  // an edge in the saturation cycle takes priority and is measured as an OOR period
  assign tout = !vs_edge && cnt_q == SAT_CLKS && state_q != NO_SIGNAL;
  assign match_inc = (cls == cand_q) ? match_q + 1'b1 : CW'(1);
  // a miss run continues only while misses stay of the same kind
  assign miss_inc = (cls == miss_cls_q) ? miss_q + 1'b1 : CW'(1);
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q    <= NO_SIGNAL;
      cnt_q      <= '0;
      period_q   <= '0;
      fmt_q      <= FORMAT_UNKNOWN;
      cand_q     <= FORMAT_UNKNOWN;
      miss_cls_q <= FORMAT_UNKNOWN;
      match_q    <= '0;
      miss_q     <= '0;
      valid_q    <= 1'b0;
      chg_q      <= 1'b0;
      lost_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      fmt_q      <= fmt_d;
      cand_q     <= cand_d;
      miss_cls_q <= miss_cls_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      valid_q    <= valid_d;
      chg_q      <= chg_d;
      lost_q     <= lost_d;
    end
  always_comb begin
    state_d = state_q;
    if (tout) state_d = NO_SIGNAL;
    else if (vs_edge)
      case (state_q)
        NO_SIGNAL: state_d = ACQUIRE;
        ACQUIRE:   state_d = (!oor && match_inc == LOCK_N) ? LOCKED : ACQUIRE;
        LOCKED:    state_d = (oor && miss_inc == LOCK_N) ? ACQUIRE : LOCKED;
        default:   state_d = NO_SIGNAL;
      endcase
  end
  always_comb begin
    cnt_d      = vs_edge ? PERIOD_W'(1) : (cnt_q == SAT_CLKS) ? cnt_q : cnt_q + 1'b1;
    period_d   = (vs_edge && state_q != NO_SIGNAL) ? cnt_q : period_q;
    fmt_d      = fmt_q;
    cand_d     = cand_q;
    miss_cls_d = miss_cls_q;
    match_d    = match_q;
    miss_d     = miss_q;
    valid_d    = valid_q;
    chg_d      = 1'b0;
    lost_d     = lost_q;
    if (tout) begin
      lost_d  = 1'b1;
      fmt_d   = FORMAT_UNKNOWN;
      valid_d = 1'b0;
      chg_d   = fmt_q != FORMAT_UNKNOWN;
    end else if (vs_edge)
      case (state_q)
        NO_SIGNAL: begin
          lost_d  = 1'b0;
          cand_d  = FORMAT_UNKNOWN;
          match_d = '0;
          miss_d  = '0;
        end
        ACQUIRE:
          if (oor) match_d = '0;
          else begin
            cand_d  = cls;
            match_d = match_inc;
            if (match_inc == LOCK_N) begin
              fmt_d   = cls;
              valid_d = 1'b1;
              chg_d   = 1'b1;
              miss_d  = '0;
            end
          end
        LOCKED:
          if (cls == fmt_q) miss_d = '0;
          else begin
            miss_cls_d = cls;
            miss_d     = miss_inc;
            if (miss_inc == LOCK_N) begin
              chg_d   = 1'b1;
              miss_d  = '0;
              fmt_d   = cls;
              valid_d = !oor;
              match_d = '0;
              cand_d  = FORMAT_UNKNOWN;
            end
          end
        default: ;
      endcase
  end
  assign csync_out         = csync_in;
  assign format_out        = fmt_q;
  assign format_valid_out  = valid_q;
  assign period_out        = period_q;
  assign format_change_out = chg_q;
  assign signal_lost_out   = lost_q;
endmodule

// File: doc/video_std_detect.md
# video_std_detect

Parametrised successor to the single-shot PAL/NTSC detector. It continuously measures the VSYNC period, classifies each period as NTSC or PAL, and declares a format only after a run of consistent periods. It tracks format changes with hysteresis and reports loss of signal, instead of stopping after one measurement. It sits on the sync input path, feeds the format code to downstream video logic, and passes composite sync through.

## Interface
- CLK_FREQ, 250_000: clock frequency in Hz.
- PERIOD_W, 32: width of the period counter and of `period_out`.
- THRESHOLD_US, 18_000: NTSC/PAL decision threshold in µs.
- MIN_PERIOD_US, 10_000: shortest valid VSYNC period in µs.
- MAX_PERIOD_US, 30_000: longest valid period in µs; also the timeout.
- LOCK_COUNT, 4: consecutive agreeing periods needed to lock or to switch format.
- Derived clock counts: X_CLKS = (CLK_FREQ/1000)*X_US/1000. At the defaults: THR 4500, MIN 2500, MAX 7500.
- clk_in  in  1  system clock; all logic is on the rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- vsync_in  in  1  raw asynchronous VSYNC.
- vsync_pol_in  in  1  active edge select: 0 = falling, 1 = rising. Quasi-static.
- csync_in  in  1  composite sync.
- csync_out  out  1  equals `csync_in` (combinational pass-through).
- format_out  out  3  000 = UNKNOWN, 010 = NTSC, 100 = PAL.
- format_valid_out  out  1  high while locked.
- period_out  out  PERIOD_W  last measured period, in clocks.
- format_change_out  out  1  one-cycle pulse whenever `format_out` changes.
- signal_lost_out  out  1  high while no VSYNC edge arrives within MAX_CLKS.

## Operation
- Edge detection:
  - `vsync_in` passes through a 2-flop synchroniser, then a delay flop.
  - An active edge is detected when the synchronised level and the delayed level differ in the direction selected by `vsync_pol_in`.
- Period counter `cnt`:
  - Loads 1 in the cycle an edge is detected, then increments by one per cycle.
  - Saturates at MAX_CLKS+1.
  - At the next edge, the measured period = `cnt`, so edges N cycles apart give a period of N.
- Classification of each measured period:
  - period < MIN_CLKS or period > MAX_CLKS: out-of-range (OOR).
  - Otherwise, period > THR_CLKS gives PAL; period ≤ THR_CLKS gives NTSC.
- `period_out` loads the measured period on every edge after the first.
- FSM states:
  - **NO_SIGNAL**: on the first edge, go to ACQUIRE and clear `signal_lost_out`.
  - **ACQUIRE**:
    - Keeps a candidate class and a match count.
    - A valid period equal to the candidate increments the count.
    - A valid period of a different class sets a new candidate with count 1.
    - An OOR period clears the count.
    - When the count reaches LOCK_COUNT: go to LOCKED, set `format_out` to the candidate, set `format_valid_out`, pulse `format_change_out`.
  - **LOCKED**:
    - A period matching `format_out` clears the miss count.
    - A period of the other valid class, or an OOR period, feeds a miss run. A miss run is consecutive misses of the same kind (same other class, or all OOR).
    - LOCK_COUNT consecutive misses of the other class: switch `format_out`, pulse `format_change_out`, stay LOCKED.
    - LOCK_COUNT consecutive OOR periods: go to ACQUIRE with count 0, set `format_out` to 000, clear valid, pulse change.
- Timeout:
  - Triggers when `cnt` reaches MAX_CLKS+1 with no edge in that cycle, from any state except NO_SIGNAL.
  - Result: go to NO_SIGNAL, set `signal_lost_out`, set `format_out` to 000, clear valid.
  - Pulse `format_change_out` only if `format_out` was not already 000.
- Simultaneous edge and saturation in the same cycle: the edge wins. The period is MAX_CLKS+1 and is treated as OOR.

## Timing
- Pin-to-detect latency is 3 cycles. All outputs are registered and update on the clock edge following the detect cycle.
- `format_change_out` is exactly one cycle wide and can never assert in back-to-back cycles.
- Reset values:
  - FSM in NO_SIGNAL; `cnt` = 0.
  - `format_out` = 000, `format_valid_out` = 0, `period_out` = 0.
  - `format_change_out` = 0, `signal_lost_out` = 1.
  - Synchroniser flops hold the inactive level for the current `vsync_pol_in`.
- Assertion of `rst_in` at any point forces all of the above immediately, without a clock.

## Structure
- Package `savomax_pkg`:
  - FORMAT_UNKNOWN, FORMAT_NTSC, FORMAT_PAL codes.
  - FSM state enum.
  - Function `us_to_clks(clk_freq, us)`.
- Sub-module `vsync_edge_sync`: synchroniser, delay flop, and polarity-selected edge pulse.
- Width of the match and miss counters = $clog2(LOCK_COUNT+1).

## Test plan
All scenarios use the default parameters and `vsync_pol_in` = 0 unless stated.
- NTSC: falling edges every 4171 clocks.
  - `format_valid_out` rises one cycle after the 5th detected edge.
  - `format_out` = 010, `period_out` = 4171, exactly one change pulse.
- PAL: edges every 5000 clocks → `format_out` = 100 after the 5th edge.
- Threshold boundary: periods of 4500 give NTSC; periods of 4501 give PAL. Periods of 2499 and 7501 never lock.
- Switch from locked NTSC:
  - Three 5000-clock periods: `format_out` stays 010.
  - A fourth 5000-clock period: `format_out` = 100 and one change pulse.
- One 1000-clock glitch period while locked: no output change. Four consecutive OOR periods: `format_out` = 000, valid = 0, one change pulse.
- VSYNC stopped while locked:
  - 7501 clocks after the last edge: `signal_lost_out` = 1, `format_out` = 000, valid = 0, one change pulse.
  - With `vsync_pol_in` = 1, rising-edge stimulus re-locks.
  - `rst_in` pulsed mid-lock drives all outputs to their reset values at once.
